// File: rtl/phy_tx_if.sv
// Word handshake and serial lane signals of the two-lane transmitter phy_tx.
interface phy_tx_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out_0;
  logic        data_out_1;
  logic        active_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out_0, data_out_1, active_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out_0, data_out_1, active_out
  );
endinterface

// File: rtl/phy_tx.sv
// Two-lane serial transmitter: splits 32-bit words over two byte lanes, MSB first, idle-fills with IDLE_CHAR.
// Optional feature: define PHY_TX_PARITY_EN to append an odd-parity bit to every byte (9-cycle byte slots).
module phy_tx #(
  parameter int unsigned SYNC_BCS  = 4,
  parameter logic [7:0]  IDLE_CHAR = 8'hBC
) (
  input  logic    clk_32f,
  input  logic    reset,
  phy_tx_if.slave bus
);

`ifdef PHY_TX_PARITY_EN
  localparam logic [3:0] BIT_LAST = 4'd8;
`else
  localparam logic [3:0] BIT_LAST = 4'd7;
`endif
  localparam int unsigned SYNC_W    = $clog2(SYNC_BCS + 2);
  localparam logic [31:0] IDLE_WORD = {4{IDLE_CHAR}};

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t            r_state;
  logic [3:0]        r_bit;
  logic              r_byte;
  logic [SYNC_W-1:0] r_sync;
  logic [31:0]       r_word;
  logic              r_ready;
  logic              r_active;
  logic              r_d0;
  logic              r_d1;

  logic              w_slot_start;
  logic              w_byte_last;
  logic              w_slot_last;
  logic              w_hs;
  logic              w_sync_done;
  logic [SYNC_W-1:0] w_sync_next;
  logic [31:0]       w_word;
  logic [7:0]        w_byte0;
  logic [7:0]        w_byte1;
  logic              w_bit0;
  logic              w_bit1;

  // The counters name the slot position whose bit is being registered on this edge.
  assign w_slot_start = (r_bit == 4'd0) && !r_byte;
  assign w_byte_last  = (r_bit == BIT_LAST);
  assign w_slot_last  = w_byte_last && r_byte;
  assign w_hs         = bus.valid_in && r_ready;
  assign w_sync_next  = r_sync + SYNC_W'(1);
  assign w_sync_done  = (r_state == ST_SYNC) && w_slot_last &&
                        (w_sync_next >= SYNC_W'(SYNC_BCS));

  // On the first edge of a slot the new word bypasses r_word so its MSB leaves one cycle after the handshake.
  assign w_word  = !w_slot_start ? r_word : (w_hs ? bus.data_in : IDLE_WORD);
  assign w_byte0 = r_byte ? w_word[23:16] : w_word[7:0];
  assign w_byte1 = r_byte ? w_word[31:24] : w_word[15:8];

`ifdef PHY_TX_PARITY_EN
  assign w_bit0 = r_bit[3] ? ~^w_byte0 : w_byte0[3'd7 - r_bit[2:0]];
  assign w_bit1 = r_bit[3] ? ~^w_byte1 : w_byte1[3'd7 - r_bit[2:0]];
`else
  assign w_bit0 = w_byte0[3'd7 - r_bit[2:0]];
  assign w_bit1 = w_byte1[3'd7 - r_bit[2:0]];
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state  <= ST_SYNC;
      r_bit    <= 4'd0;
      r_byte   <= 1'b0;
      r_sync   <= '0;
      r_word   <= '0;
      r_ready  <= 1'b0;
      r_active <= 1'b0;
      r_d0     <= 1'b0;
      r_d1     <= 1'b0;
    end else begin
      r_d0 <= w_bit0;
      r_d1 <= w_bit1;

      if (w_slot_start) begin
        r_word   <= w_word;
        r_active <= w_hs;
      end

      // Ready is offered only on the final cycle of a word slot, including the last sync slot.
      r_ready <= w_slot_last && ((r_state == ST_RUN) || w_sync_done);

      if (w_byte_last) begin
        r_bit  <= 4'd0;
        r_byte <= ~r_byte;
      end else begin
        r_bit <= r_bit + 4'd1;
      end

      if ((r_state == ST_SYNC) && w_byte_last) begin
        r_sync <= w_sync_next;
        if (w_sync_done) r_state <= ST_RUN;
      end
    end
  end

  assign bus.ready_out  = r_ready;
  assign bus.active_out = r_active;
  assign bus.data_out_0 = r_d0;
  assign bus.data_out_1 = r_d1;

endmodule

// File: tb/tb_phy_tx.sv
// Scoreboard bench for phy_tx: a slot-level model queues expected per-cycle lane output, a monitor compares.
module tb_phy_tx;

`ifdef PHY_TX_PARITY_EN
  localparam int BYTE_CYC = 9;
`else
  localparam int BYTE_CYC = 8;
`endif
  localparam int SLOT      = 2 * BYTE_CYC;
  localparam int SYNC_BCS  = 4;
  localparam int SYNC_LEN  = ((SYNC_BCS + 1) / 2) * SLOT;
  localparam logic [31:0] IDLE_WORD = 32'hBCBCBCBC;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_32f = ~clk_32f;

  phy_tx_if bus ();

  phy_tx #(.SYNC_BCS(SYNC_BCS), .IDLE_CHAR(8'hBC)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus.slave)
  );

  // Expected {ready, active, lane0, lane1} per cycle, oldest first.
  logic [3:0] exp_q[$];
  int cyc       = -1;
  int next_slot = 0;
  int n_pass    = 0;
  int n_total   = 0;
  bit mon_en    = 1'b0;
  bit accepted  = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b want=%b ({ready,active,d0,d1})", name, cyc, act, exp);
  endtask

  // Expands one word slot into its serial bit pattern for both lanes.
  task automatic push_slot(input logic [31:0] w, input bit act);
    logic [7:0] b0, b1;
    logic       x0, x1, rdy;
    for (int b = 0; b < 2; b++) begin
      b0 = (b == 1) ? w[23:16] : w[7:0];
      b1 = (b == 1) ? w[31:24] : w[15:8];
      for (int k = 0; k < BYTE_CYC; k++) begin
        x0  = (k < 8) ? b0[7 - k] : ($countones(b0) % 2 == 0);
        x1  = (k < 8) ? b1[7 - k] : ($countones(b1) % 2 == 0);
        rdy = (b == 1) && (k == BYTE_CYC - 1) && ((next_slot + 1) * SLOT >= SYNC_LEN);
        exp_q.push_back({rdy, act, x0, x1});
      end
    end
    next_slot++;
  endtask

  // One clock cycle: drive inputs for cycle cyc and let the model decide the next slot.
  task automatic step(input bit v, input logic [31:0] d);
    @(posedge clk_32f);
    #1;
    cyc++;
    if (cyc == 0) mon_en = 1'b1;
    bus.valid_in = v;
    bus.data_in  = d;
    accepted     = 1'b0;
    if (cyc % SLOT == SLOT - 1) begin
      if (v && (cyc + 1 >= SYNC_LEN)) begin
        push_slot(d, 1'b1);
        accepted = 1'b1;
      end else begin
        push_slot(IDLE_WORD, 1'b0);
      end
    end
  endtask

  // Holds valid high until the model says the word was taken; noisy mode scrambles data off the ready cycle.
  task automatic send_word(input logic [31:0] d, input bit noisy);
    int  guard;
    bit  rdy_next;
    guard = 0;
    do begin
      rdy_next = ((cyc + 1) % SLOT == SLOT - 1) && (cyc + 2 >= SYNC_LEN);
      step(1'b1, (noisy && !rdy_next) ? 32'($urandom) : d);
      guard++;
    end while (!accepted && guard < 4 * SLOT + SYNC_LEN);
    if (!accepted) begin
      n_total++;
      $display("FAIL send_word_timeout cyc=%0d got=not_accepted want=accepted", cyc);
    end
  endtask

  task automatic release_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    exp_q.delete();
    cyc       = -1;
    next_slot = 0;
    push_slot(IDLE_WORD, 1'b0);
  endtask

  // Monitor: compares one expected entry per cycle, sampled on the falling edge.
  initial begin
    logic [3:0] act;
    forever begin
      @(negedge clk_32f);
      if (mon_en) begin
        act = {bus.ready_out, bus.active_out, bus.data_out_0, bus.data_out_1};
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty cyc=%0d got=%b want=queued_entry", cyc, act);
        end else begin
          check("lane", act, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;

    repeat (3) @(posedge clk_32f);
    #2;
    check("reset_state", {bus.ready_out, bus.active_out, bus.data_out_0, bus.data_out_1}, 4'b0000);
    release_reset();

    // Sync sequence with valid low, then a word offered early and taken at the end of sync.
    repeat (20) step(1'b0, 32'($urandom));
    send_word(32'hDEADBEEF, 1'b0);
    repeat (SLOT) step(1'b0, 32'h0);

    // Back-to-back words with valid held high.
    send_word(32'h00000001, 1'b0);
    send_word(32'h80000000, 1'b0);
    // Data scrambled while ready is low; payload byte equal to the idle character.
    send_word(32'h13579BDF, 1'b1);
    send_word(32'h000000BC, 1'b0);
    repeat (SLOT + 3) step(1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      if ($urandom_range(3) == 0) d[15:8] = 8'hBC;
      step($urandom_range(2) != 0, d);
    end

    // Reset five cycles into a payload slot; the in-flight word must never appear.
    send_word(32'hA5A51234, 1'b0);
    while (cyc % SLOT != 5) step(1'b0, 32'h0);
    mon_en       = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("reset_async", {bus.ready_out, bus.active_out, bus.data_out_0, bus.data_out_1}, 4'b0000);
    repeat (2) @(posedge clk_32f);
    #1;
    check("reset_hold", {bus.ready_out, bus.active_out, bus.data_out_0, bus.data_out_1}, 4'b0000);
    release_reset();
    repeat (10) step(1'b0, 32'h0);
    send_word(32'hCAFEF00D, 1'b0);
    repeat (SLOT + 3) step(1'b0, 32'h0);

    mon_en = 1'b0;
    if (exp_q.size() < 2 * SLOT) n_pass++;
    else $display("FAIL scoreboard_backlog got=%0d want=<%0d", exp_q.size(), 2 * SLOT);
    n_total++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
